// File: rtl/slot_wr_scheduler.sv
// slot_wr_scheduler: queues slot parameter writes and issues each one the cycle after the datapath visits that slot
module slot_wr_scheduler #(
  parameter int VOICES  = 8,
  parameter int V_ENVS  = 8,
  parameter int V_WIDTH = 3,
  parameter int E_WIDTH = 3,
  parameter int D_WIDTH = 16,
  parameter int DEPTH   = 4
) (
  input  logic                       sCLK_XVXENVS,
  input  logic                       reset_reg,
  input  logic [V_WIDTH+E_WIDTH-1:0] xxxx,
  input  logic                       xxxx_zero,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [V_WIDTH+E_WIDTH-1:0] req_slot,
  input  logic [D_WIDTH-1:0]         req_data,
  output logic                       wr_en,
  output logic [V_WIDTH+E_WIDTH-1:0] wr_addr,
  output logic [D_WIDTH-1:0]         wr_data,
  output logic [$clog2(DEPTH):0]     pending,
  output logic                       synced,
  output logic                       slot_err
);
  localparam int SW = V_WIDTH + E_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] NSLOT = 32'(VOICES * V_ENVS);
  typedef enum logic [1:0] {SYNC, IDLE, WAIT, ISSUE} state_t;
  state_t state_q, state_d;
  logic [SW-1:0]      slot_q [DEPTH];
  logic [D_WIDTH-1:0] data_q [DEPTH];
  logic [AW-1:0]      wptr_q, rptr_q;
  logic [AW:0]        cnt_q;
  logic               err_q, wr_en_q;
  logic [SW-1:0]      wr_addr_q;
  logic [D_WIDTH-1:0] wr_data_q;
  logic               acc, push, pop;
  assign req_ready = cnt_q < (AW+1)'(DEPTH);
  assign acc       = req_valid && req_ready;
  assign push      = acc && (32'(req_slot) < NSLOT);
  // popping only from WAIT keeps an ISSUE cycle between writes, so a head matching xxxx during ISSUE waits a frame
  assign pop       = (state_q == WAIT) && (xxxx == slot_q[rptr_q]);
  assign pending   = cnt_q;
  assign synced    = state_q != SYNC;
  assign slot_err  = err_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  always_comb begin
    state_d = state_q == SYNC ? (xxxx_zero ? IDLE : SYNC)
            : state_q == IDLE ? (cnt_q != 0 ? WAIT : IDLE)
            : state_q == WAIT ? (pop ? ISSUE : WAIT)
            : (cnt_q != 0 ? WAIT : IDLE);
  end
  always_ff @(posedge sCLK_XVXENVS) begin
    if (push) begin
      slot_q[wptr_q] <= req_slot;
      data_q[wptr_q] <= req_data;
    end
  end
  always_ff @(posedge sCLK_XVXENVS or posedge reset_reg) begin
    if (reset_reg) begin
      state_q   <= SYNC;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_q + AW'(push);
      rptr_q  <= rptr_q + AW'(pop);
      cnt_q   <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      wr_en_q <= pop;
      if (acc && !push) err_q <= 1'b1;
      if (pop) begin
        wr_addr_q <= slot_q[rptr_q];
        wr_data_q <= data_q[rptr_q];
      end
    end
  end
endmodule

// File: tb/tb_slot_wr_scheduler.sv
// tb_slot_wr_scheduler: directed scenarios against a free-running 0..63 slot counter
module tb_slot_wr_scheduler;
  logic        clk = 1'b0;
  logic        reset_reg = 1'b1;
  logic [6:0]  xxxx = 7'd0;
  logic        xxxx_zero = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [6:0]  req_slot = 7'd0;
  logic [15:0] req_data = 16'd0;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  pending;
  logic        synced, slot_err;
  int total = 0, bad = 0;
  int wa[8], wd[8], wx[8], wp[8], wt[8];
  int ncol;

  slot_wr_scheduler #(.VOICES(8), .V_ENVS(8), .V_WIDTH(4), .E_WIDTH(3), .D_WIDTH(16), .DEPTH(4)) dut (
    .sCLK_XVXENVS(clk), .reset_reg(reset_reg), .xxxx(xxxx), .xxxx_zero(xxxx_zero),
    .req_valid(req_valid), .req_ready(req_ready), .req_slot(req_slot), .req_data(req_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pending(pending),
    .synced(synced), .slot_err(slot_err));

  initial forever #5 clk = ~clk;

  // 64-slot frame: slot index advances shortly after each rising edge, wrap flag on slot 63
  initial forever begin
    @(posedge clk);
    #2;
    xxxx = (xxxx == 7'd63) ? 7'd0 : xxxx + 7'd1;
    xxxx_zero = (xxxx == 7'd63);
  end

  task automatic wait_x(input int v);
    for (int i = 0; i < 70 && int'(xxxx) != v; i++) @(negedge clk);
  endtask

  task automatic push(input logic [6:0] s, input logic [15:0] d);
    req_valid = 1'b1; req_slot = s; req_data = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic collect(input int budget);
    ncol = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (wr_en) begin
        if (ncol < 8) begin
          wa[ncol] = int'(wr_addr); wd[ncol] = int'(wr_data);
          wx[ncol] = int'(xxxx); wp[ncol] = int'(pending); wt[ncol] = c;
        end
        ncol++;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en: got %0b want 0", wr_en); end
    total++; if (wr_addr !== 7'd0) begin bad++; $display("FAIL rst_wr_addr: got %0d want 0", wr_addr); end
    total++; if (wr_data !== 16'd0) begin bad++; $display("FAIL rst_wr_data: got %0h want 0", wr_data); end
    total++; if (pending !== 3'd0) begin bad++; $display("FAIL rst_pending: got %0d want 0", pending); end
    total++; if (synced !== 1'b0) begin bad++; $display("FAIL rst_synced: got %0b want 0", synced); end
    total++; if (slot_err !== 1'b0) begin bad++; $display("FAIL rst_slot_err: got %0b want 0", slot_err); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready: got %0b want 1", req_ready); end
    wait_x(1);
    reset_reg = 1'b0;
  endtask

  task automatic test_sync_first;
    wait_x(5);
    push(7'd10, 16'h1234);
    total++; if (pending !== 3'd1) begin bad++; $display("FAIL sync_pending: got %0d want 1", pending); end
    total++; if (synced !== 1'b0) begin bad++; $display("FAIL sync_presync: got %0b want 0", synced); end
    collect(140);
    total++; if (ncol !== 1) begin bad++; $display("FAIL sync_count: got %0d want 1", ncol); end
    total++; if (wt[0] !== 68) begin bad++; $display("FAIL sync_when: got cycle %0d want 68", wt[0]); end
    total++; if (wa[0] !== 10) begin bad++; $display("FAIL sync_addr: got %0d want 10", wa[0]); end
    total++; if (wd[0] !== 'h1234) begin bad++; $display("FAIL sync_data: got %0h want 1234", wd[0]); end
    total++; if (synced !== 1'b1) begin bad++; $display("FAIL sync_synced: got %0b want 1", synced); end
  endtask

  task automatic test_order;
    int ea[3] = '{5, 3, 40};
    int ed[3] = '{'hA005, 'hA003, 'hA040};
    int ex[3] = '{6, 4, 41};
    int ep[3] = '{2, 1, 0};
    wait_x(20);
    push(7'd5, 16'hA005);
    push(7'd3, 16'hA003);
    push(7'd40, 16'hA040);
    total++; if (pending !== 3'd3) begin bad++; $display("FAIL order_pending: got %0d want 3", pending); end
    collect(200);
    total++; if (ncol !== 3) begin bad++; $display("FAIL order_count: got %0d want 3", ncol); end
    for (int i = 0; i < 3 && i < ncol; i++) begin
      total++; if (wa[i] !== ea[i]) begin bad++; $display("FAIL order_addr[%0d]: got %0d want %0d", i, wa[i], ea[i]); end
      total++; if (wd[i] !== ed[i]) begin bad++; $display("FAIL order_data[%0d]: got %0h want %0h", i, wd[i], ed[i]); end
      total++; if (wx[i] !== ex[i]) begin bad++; $display("FAIL order_slot_time[%0d]: got %0d want %0d", i, wx[i], ex[i]); end
      total++; if (wp[i] !== ep[i]) begin bad++; $display("FAIL order_pending[%0d]: got %0d want %0d", i, wp[i], ep[i]); end
    end
  endtask

  task automatic test_full;
    bit seen = 0;
    wait_x(52);
    for (int i = 0; i < 4; i++) push(7'(50 + i), 16'(16'hB050 + i));
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %0b want 0", req_ready); end
    total++; if (pending !== 3'd4) begin bad++; $display("FAIL full_pending: got %0d want 4", pending); end
    req_valid = 1'b1; req_slot = 7'd54; req_data = 16'hB054;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      seen = req_ready;
    end
    total++; if (!seen) begin bad++; $display("FAIL full_ready_timeout: got ready 0 want 1"); end
    total++; if (xxxx !== 7'd51) begin bad++; $display("FAIL full_ready_when: got slot %0d want 51", xxxx); end
    total++; if (pending !== 3'd3) begin bad++; $display("FAIL full_pending_pop: got %0d want 3", pending); end
    total++; if (wr_en !== 1'b1 || wr_addr !== 7'd50) begin bad++; $display("FAIL full_first_wr: got en %0b addr %0d want en 1 addr 50", wr_en, wr_addr); end
    @(negedge clk);
    req_valid = 1'b0;
    total++; if (pending !== 3'd4) begin bad++; $display("FAIL full_fifth: got %0d want 4", pending); end
    collect(300);
    total++; if (ncol !== 4) begin bad++; $display("FAIL full_count: got %0d want 4", ncol); end
    for (int i = 0; i < 4 && i < ncol; i++) begin
      total++; if (wa[i] !== 51 + i || wd[i] !== 'hB051 + i || wx[i] !== 52 + i) begin
        bad++; $display("FAIL full_drain[%0d]: got addr %0d data %0h slot %0d want %0d %0h %0d", i, wa[i], wd[i], wx[i], 51 + i, 'hB051 + i, 52 + i);
      end
    end
  endtask

  task automatic test_err;
    push(7'd64, 16'hDEAD);
    total++; if (slot_err !== 1'b1) begin bad++; $display("FAIL err_flag: got %0b want 1", slot_err); end
    total++; if (pending !== 3'd0) begin bad++; $display("FAIL err_pending: got %0d want 0", pending); end
    collect(70);
    total++; if (ncol !== 0) begin bad++; $display("FAIL err_writes: got %0d want 0", ncol); end
    total++; if (slot_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %0b want 1", slot_err); end
  endtask

  task automatic test_same_slot;
    push(7'd7, 16'h0701);
    push(7'd7, 16'h0702);
    collect(200);
    total++; if (ncol !== 2) begin bad++; $display("FAIL same_count: got %0d want 2", ncol); end
    total++; if (wa[0] !== 7 || wa[1] !== 7) begin bad++; $display("FAIL same_addr: got %0d,%0d want 7,7", wa[0], wa[1]); end
    total++; if (wd[0] !== 'h0701 || wd[1] !== 'h0702) begin bad++; $display("FAIL same_data: got %0h,%0h want 701,702", wd[0], wd[1]); end
    total++; if (wt[1] - wt[0] !== 64) begin bad++; $display("FAIL same_gap: got %0d want 64", wt[1] - wt[0]); end
  endtask

  task automatic test_reset_mid;
    bit seen = 0;
    push(7'd60, 16'h6060);
    push(7'd61, 16'h6161);
    push(7'd62, 16'h6262);
    total++; if (pending !== 3'd3) begin bad++; $display("FAIL mid_pending_pre: got %0d want 3", pending); end
    reset_reg = 1'b1;
    #1;
    total++; if (pending !== 3'd0) begin bad++; $display("FAIL mid_pending: got %0d want 0", pending); end
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL mid_wr_en: got %0b want 0", wr_en); end
    total++; if (synced !== 1'b0) begin bad++; $display("FAIL mid_synced: got %0b want 0", synced); end
    total++; if (slot_err !== 1'b0) begin bad++; $display("FAIL mid_slot_err: got %0b want 0", slot_err); end
    @(negedge clk);
    reset_reg = 1'b0;
    collect(130);
    total++; if (ncol !== 0) begin bad++; $display("FAIL mid_discard: got %0d writes want 0", ncol); end
    total++; if (synced !== 1'b1) begin bad++; $display("FAIL mid_resync: got %0b want 1", synced); end
    push(7'd58, 16'h5858);
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      seen = wr_en;
    end
    total++; if (!seen || wr_addr !== 7'd58 || wr_data !== 16'h5858) begin
      bad++; $display("FAIL cut_strobe: got en %0b addr %0d data %0h want 1 58 5858", seen, wr_addr, wr_data);
    end
    reset_reg = 1'b1;
    #1;
    total++; if (wr_en !== 1'b0 || wr_addr !== 7'd0) begin bad++; $display("FAIL cut_off: got en %0b addr %0d want 0 0", wr_en, wr_addr); end
    @(negedge clk);
    reset_reg = 1'b0;
  endtask

  initial begin
    test_reset;
    test_sync_first;
    test_order;
    test_full;
    test_err;
    test_same_slot;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
